// File: rtl/e_mdu.sv
// rtl/e_mdu.sv - E-stage multicycle multiply/divide unit owning HI/LO
// Result is computed at Start and held pending; HI/LO update when the busy countdown expires.
module e_mdu #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] SrcA,
  input  logic [31:0] SrcB,
  input  logic [3:0]  MDU_Control,
  input  logic        Start,
  output logic        Busy,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output logic [31:0] MDU_Result
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW = $clog2(MAX_CYCLES + 1);

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MTHI  = 4'd5;
  localparam logic [3:0] OP_MTLO  = 4'd6;
  localparam logic [3:0] OP_MFHI  = 4'd7;
  localparam logic [3:0] OP_MFLO  = 4'd8;

  logic [CW-1:0] cnt_q, cnt_d;
  logic          busy_q, busy_d;
  logic [31:0]   hi_q, hi_d, lo_q, lo_d;
  logic [31:0]   pend_hi_q, pend_hi_d, pend_lo_q, pend_lo_d;
  logic [31:0]   a_q, a_d, b_q, b_d;
  logic [3:0]    op_q, op_d;

  logic               accept, wr_ok, is_mul;
  logic signed [63:0] sa64, sb64, prod_s;
  logic [63:0]        prod_u;
  logic [31:0]        abs_a, abs_b, div_u, div_s;
  logic [31:0]        uq, ur, sq_mag, sr_mag, sq, sr;

  always_comb begin
    accept = Start && (cnt_q == '0) &&
             (MDU_Control inside {OP_MULT, OP_MULTU, OP_DIV, OP_DIVU});
    is_mul = (MDU_Control == OP_MULT) || (MDU_Control == OP_MULTU);

    sa64   = {{32{SrcA[31]}}, SrcA};
    sb64   = {{32{SrcB[31]}}, SrcB};
    prod_s = sa64 * sb64;
    prod_u = {32'b0, SrcA} * {32'b0, SrcB};

    // Signed divide via magnitudes so 0x80000000 / -1 wraps cleanly to 0x80000000.
    abs_a  = SrcA[31] ? -SrcA : SrcA;
    abs_b  = SrcB[31] ? -SrcB : SrcB;
    div_u  = (SrcB == '0) ? 32'd1 : SrcB;
    div_s  = (abs_b == '0) ? 32'd1 : abs_b;
    uq     = SrcA / div_u;
    ur     = SrcA % div_u;
    sq_mag = abs_a / div_s;
    sr_mag = abs_a % div_s;
    sq     = (SrcA[31] ^ SrcB[31]) ? -sq_mag : sq_mag;
    sr     = SrcA[31] ? -sr_mag : sr_mag;

    // A divide by zero runs its full duration but leaves HI/LO untouched.
    wr_ok  = !(((op_q == OP_DIV) || (op_q == OP_DIVU)) && (b_q == '0));

    cnt_d     = cnt_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    pend_hi_d = pend_hi_q;
    pend_lo_d = pend_lo_q;
    a_d       = a_q;
    b_d       = b_q;
    op_d      = op_q;

    if (accept) begin
      a_d   = SrcA;
      b_d   = SrcB;
      op_d  = MDU_Control;
      cnt_d = is_mul ? CW'(MULT_CYCLES) : CW'(DIV_CYCLES);
      case (MDU_Control)
        OP_MULT:  {pend_hi_d, pend_lo_d} = prod_s;
        OP_MULTU: {pend_hi_d, pend_lo_d} = prod_u;
        OP_DIV:   begin pend_hi_d = sr; pend_lo_d = sq; end
        default:  begin pend_hi_d = ur; pend_lo_d = uq; end
      endcase
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CW'(1);
      if ((cnt_q == CW'(1)) && wr_ok) begin
        hi_d = pend_hi_q;
        lo_d = pend_lo_q;
      end
    end else if (!Start) begin
      if (MDU_Control == OP_MTHI) hi_d = SrcA;
      if (MDU_Control == OP_MTLO) lo_d = SrcA;
    end

    busy_d = (cnt_d != '0);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q     <= '0;
      busy_q    <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      pend_hi_q <= '0;
      pend_lo_q <= '0;
      a_q       <= '0;
      b_q       <= '0;
      op_q      <= '0;
    end else begin
      cnt_q     <= cnt_d;
      busy_q    <= busy_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      pend_hi_q <= pend_hi_d;
      pend_lo_q <= pend_lo_d;
      a_q       <= a_d;
      b_q       <= b_d;
      op_q      <= op_d;
    end
  end

  always_comb begin
    case (MDU_Control)
      OP_MFHI: MDU_Result = hi_q;
      OP_MFLO: MDU_Result = lo_q;
      default: MDU_Result = 32'b0;
    endcase
  end

  // The latched dividend is kept for debug visibility alongside the divisor and op.
  logic unused_a;
  assign unused_a = ^a_q;

  assign Busy = busy_q;
  assign HI   = hi_q;
  assign LO   = lo_q;

endmodule

// File: tb/tb_e_mdu.sv
// tb/tb_e_mdu.sv - scoreboard bench for e_mdu with randomized mult/div traffic
module tb_e_mdu;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] SrcA = '0, SrcB = '0;
  logic [3:0]  MDU_Control = '0;
  logic        Start = 1'b0;
  logic        Busy;
  logic [31:0] HI, LO, MDU_Result;

  always #5 clk = ~clk;

  e_mdu #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset(reset), .SrcA(SrcA), .SrcB(SrcB),
    .MDU_Control(MDU_Control), .Start(Start), .Busy(Busy),
    .HI(HI), .LO(LO), .MDU_Result(MDU_Result)
  );

  typedef struct { logic [31:0] hi; logic [31:0] lo; int len; string nm; } op_exp_t;
  typedef struct { logic [31:0] hi; logic [31:0] lo; logic [31:0] res; string nm; } pr_exp_t;

  op_exp_t     op_sb[$];
  pr_exp_t     pr_sb[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  logic [31:0] m_hi = '0, m_lo = '0;
  logic        probe = 1'b0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input string nm);
    int k = 0;
    while (Busy !== 1'b0 && k < 40) begin
      step();
      k++;
    end
    if (Busy !== 1'b0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s_timeout: Busy=%b expected 0", nm, Busy);
    end
  endtask

  // Reference model: plain 64-bit arithmetic on the architectural HI/LO.
  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b, input string nm);
    longint  la, lb, q, r;
    logic [63:0] p;
    op_exp_t e;
    la = longint'($signed(a));
    lb = longint'($signed(b));
    case (op)
      4'd1: begin p = la * lb; m_hi = p[63:32]; m_lo = p[31:0]; end
      4'd2: begin p = {32'b0, a} * {32'b0, b}; m_hi = p[63:32]; m_lo = p[31:0]; end
      4'd3: if (b != 0) begin q = la / lb; r = la % lb; m_lo = q[31:0]; m_hi = r[31:0]; end
      default: if (b != 0) begin m_lo = a / b; m_hi = a % b; end
    endcase
    e.hi = m_hi; e.lo = m_lo; e.len = (op <= 4'd2) ? 5 : 10; e.nm = nm;
    op_sb.push_back(e);
    SrcA = a; SrcB = b; MDU_Control = op; Start = 1'b1;
    step();
    Start = 1'b0; MDU_Control = 4'd0;
  endtask

  task automatic mt(input logic [3:0] op, input logic [31:0] v);
    MDU_Control = op; SrcA = v;
    step();
    if (op == 4'd5) m_hi = v; else m_lo = v;
    MDU_Control = 4'd0;
  endtask

  task automatic probe_chk(input logic [3:0] ctl, input string nm);
    pr_exp_t e;
    e.hi = m_hi; e.lo = m_lo; e.nm = nm;
    e.res = (ctl == 4'd7) ? m_hi : (ctl == 4'd8) ? m_lo : 32'd0;
    pr_sb.push_back(e);
    MDU_Control = ctl; probe = 1'b1;
    step();
    probe = 1'b0; MDU_Control = 4'd0;
  endtask

  // Monitor: completions are detected on Busy falling, probes on the probe strobe.
  logic        prev_busy = 1'b0;
  int          bcnt = 0;
  logic        hold_ok = 1'b1;
  logic [31:0] hold_hi, hold_lo;
  always @(negedge clk) begin
    op_exp_t oe;
    pr_exp_t pe;
    if (Busy === 1'b1) begin
      if (!prev_busy) begin
        hold_hi = HI; hold_lo = LO; hold_ok = 1'b1;
      end else if (HI !== hold_hi || LO !== hold_lo) begin
        hold_ok = 1'b0;
      end
      bcnt++;
    end else if (prev_busy) begin
      if (op_sb.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL unexpected_completion: got result with empty scoreboard expected none");
      end else begin
        oe = op_sb.pop_front();
        check({oe.nm, "_hi"}, HI, oe.hi);
        check({oe.nm, "_lo"}, LO, oe.lo);
        check({oe.nm, "_busy_len"}, 32'(bcnt), 32'(oe.len));
        check({oe.nm, "_hold"}, {31'b0, hold_ok}, 32'd1);
      end
      bcnt = 0;
    end
    if (probe) begin
      if (pr_sb.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL unexpected_probe: got probe with empty scoreboard expected none");
      end else begin
        pe = pr_sb.pop_front();
        check({pe.nm, "_hi"}, HI, pe.hi);
        check({pe.nm, "_lo"}, LO, pe.lo);
        check({pe.nm, "_res"}, MDU_Result, pe.res);
        check({pe.nm, "_busy"}, {31'b0, Busy}, 32'd0);
      end
    end
    prev_busy = (Busy === 1'b1);
  end

  initial begin
    logic [3:0]  rop;
    logic [31:0] ra, rb;
    op_exp_t     e;

    repeat (2) step();
    reset = 1'b0;
    probe_chk(4'd0, "reset");

    issue(4'd1, 32'hFFFF_FFFF, 32'h2, "mult");      wait_idle("mult");
    issue(4'd2, 32'hFFFF_FFFF, 32'h2, "multu");     wait_idle("multu");
    issue(4'd3, 32'hFFFF_FFF9, 32'h2, "div_neg");   wait_idle("div_neg");
    issue(4'd4, 32'd7, 32'd2, "divu");              wait_idle("divu");
    issue(4'd3, 32'h8000_0000, 32'hFFFF_FFFF, "div_ovf"); wait_idle("div_ovf");

    mt(4'd5, 32'h1111);
    mt(4'd6, 32'h2222);
    probe_chk(4'd7, "preload");
    issue(4'd3, 32'd5, 32'd0, "div_zero");          wait_idle("div_zero");

    // Start and mthi while busy must be ignored.
    issue(4'd1, 32'hFFFF_FFFF, 32'h2, "mult_busy");
    step();
    SrcA = 32'd7; SrcB = 32'd2; MDU_Control = 4'd4; Start = 1'b1;
    step();
    Start = 1'b0; MDU_Control = 4'd5; SrcA = 32'h1234;
    step();
    MDU_Control = 4'd0;
    wait_idle("mult_busy");
    mt(4'd5, 32'h1234);
    probe_chk(4'd7, "mfhi");
    probe_chk(4'd8, "mflo");
    probe_chk(4'd0, "none");

    // Reset in the third busy cycle of a divide.
    m_hi = '0; m_lo = '0;
    e.hi = '0; e.lo = '0; e.len = 3; e.nm = "abort";
    op_sb.push_back(e);
    SrcA = 32'd100; SrcB = 32'd7; MDU_Control = 4'd3; Start = 1'b1;
    step();
    Start = 1'b0; MDU_Control = 4'd0;
    step();
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    repeat (12) step();
    probe_chk(4'd0, "post_abort");

    // Random back-to-back traffic.
    for (int i = 0; i < 30; i++) begin
      rop = 4'($urandom_range(1, 4));
      ra  = $urandom;
      case ($urandom_range(0, 5))
        0: rb = 32'd0;
        1: rb = 32'hFFFF_FFFF;
        2: rb = 32'($urandom_range(1, 9));
        default: rb = $urandom;
      endcase
      if ($urandom_range(0, 7) == 0) ra = 32'h8000_0000;
      issue(rop, ra, rb, $sformatf("rnd%0d_op%0d", i, rop));
      wait_idle("rnd");
      if ($urandom_range(0, 3) == 0) probe_chk(4'd8, "rnd_mflo");
    end

    repeat (3) step();
    check("scoreboard_drained", 32'(op_sb.size() + pr_sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached expected completion");
    $fatal(1);
  end

endmodule
